// File: rtl/code_lock_seq.sv
// Multi-digit keypad code lock with failure counting and timed lockout.
// Optional ENTRY_TIMEOUT_EN discards a partial entry after ENTRY_TIMEOUT idle cycles.
module code_lock_seq #(
    parameter int DIGITS        = 4,
    parameter int DIGIT_W       = 4,
    parameter int OPEN_CYCLES   = 16,
    parameter int MAX_FAILS     = 3,
    parameter int LOCK_CYCLES   = 64,
    parameter int ENTRY_TIMEOUT = 1000
) (
    input  logic                             clk,
    input  logic                             clr_n,
    input  logic [DIGITS*DIGIT_W-1:0]        code,
    input  logic                             key_valid,
    input  logic [DIGIT_W-1:0]               key,
    input  logic                             cancel,
    output logic                             pass,
    output logic                             fail,
    output logic                             locked,
    output logic [$clog2(DIGITS+1)-1:0]      digit_cnt,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

    localparam int CW   = $clog2(DIGITS+1);
    localparam int FW   = $clog2(MAX_FAILS+1);
    localparam int TM0  = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TMAX = (TM0 > ENTRY_TIMEOUT) ? TM0 : ENTRY_TIMEOUT;
    localparam int TW   = $clog2(TMAX+1);

    typedef enum logic [1:0] {
        S_ENTRY = 2'd0,
        S_OPEN  = 2'd1,
        S_FAIL  = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     digit_cnt_q, digit_cnt_d;
    logic [FW-1:0]     fail_cnt_q, fail_cnt_d;
    logic              mismatch_q, mismatch_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              pass_q, fail_q, locked_q;
    logic [DIGIT_W-1:0] exp_digit;
    logic              miss;

    // Reference digit for the current position, taken from the live code bus.
    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_cnt_q == CW'(i)) begin
                exp_digit = code[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        mismatch_d  = mismatch_q;
        timer_d     = timer_q;
        miss        = mismatch_q | (key != exp_digit);
        case (state_q)
            S_ENTRY: begin
                if (cancel) begin
                    digit_cnt_d = '0;
                    mismatch_d  = 1'b0;
                    timer_d     = '0;
                end else if (key_valid) begin
                    if (digit_cnt_q == CW'(DIGITS-1)) begin
                        digit_cnt_d = '0;
                        mismatch_d  = 1'b0;
                        if (miss) begin
                            state_d    = S_FAIL;
                            timer_d    = '0;
                            fail_cnt_d = (fail_cnt_q == FW'(MAX_FAILS)) ?
                                         fail_cnt_q : fail_cnt_q + FW'(1);
                        end else begin
                            state_d    = S_OPEN;
                            timer_d    = TW'(OPEN_CYCLES-1);
                            fail_cnt_d = '0;
                        end
                    end else begin
                        digit_cnt_d = digit_cnt_q + CW'(1);
                        mismatch_d  = miss;
`ifdef ENTRY_TIMEOUT_EN
                        timer_d     = TW'(ENTRY_TIMEOUT);
`endif
                    end
                end
`ifdef ENTRY_TIMEOUT_EN
                else if (digit_cnt_q != '0) begin
                    if (timer_q <= TW'(1)) begin
                        digit_cnt_d = '0;
                        mismatch_d  = 1'b0;
                        timer_d     = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
`endif
            end
            S_OPEN: begin
                if (cancel || timer_q == '0) begin
                    state_d = S_ENTRY;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_FAIL: begin
                if (fail_cnt_q == FW'(MAX_FAILS)) begin
                    state_d = S_LOCK;
                    timer_d = TW'(LOCK_CYCLES-1);
                end else begin
                    state_d = S_ENTRY;
                end
            end
            S_LOCK: begin
                if (timer_q == '0) begin
                    state_d     = S_ENTRY;
                    fail_cnt_d  = '0;
                    digit_cnt_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d     = S_ENTRY;
                digit_cnt_d = '0;
                fail_cnt_d  = '0;
                mismatch_d  = 1'b0;
                timer_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= S_ENTRY;
            digit_cnt_q <= '0;
            fail_cnt_q  <= '0;
            mismatch_q  <= 1'b0;
            timer_q     <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            mismatch_q  <= mismatch_d;
            timer_q     <= timer_d;
            pass_q      <= (state_d == S_OPEN);
            fail_q      <= (state_d == S_FAIL);
            locked_q    <= (state_d == S_LOCK);
        end
    end

    assign pass      = pass_q;
    assign fail      = fail_q;
    assign locked    = locked_q;
    assign digit_cnt = digit_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_code_lock_seq.sv
// Scoreboard bench for code_lock_seq: pass/fail/locked windows are
// measured by a monitor and matched against expected events in order.
module tb_code_lock_seq;

    localparam int K_PASS = 0;
    localparam int K_FAIL = 1;
    localparam int K_LOCK = 2;

    typedef struct {
        int kind;
        int len;
    } ev_t;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [15:0] code;
    logic        key_valid;
    logic [3:0]  key;
    logic        cancel;
    logic        pass, fail, locked;
    logic [2:0]  digit_cnt;
    logic [1:0]  fail_cnt;

    int total = 0;
    int bad   = 0;
    ev_t exp_q[$];

    code_lock_seq #(
        .ENTRY_TIMEOUT(10)
    ) dut (
        .clk(clk),
        .clr_n(clr_n),
        .code(code),
        .key_valid(key_valid),
        .key(key),
        .cancel(cancel),
        .pass(pass),
        .fail(fail),
        .locked(locked),
        .digit_cnt(digit_cnt),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic expect_ev(input int kind, input int len);
        ev_t e;
        e.kind = kind;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic report(input int kind, input int len);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("sb_unexpected_kind", kind, -1);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_len", len, e.len);
        end
    endtask

    // Monitor: measures each high window of pass/fail/locked.
    initial begin
        int pl, fl, ll;
        pl = 0; fl = 0; ll = 0;
        forever begin
            @(negedge clk);
            if (pass === 1'b1) pl++;
            else if (pl > 0) begin report(K_PASS, pl); pl = 0; end
            if (fail === 1'b1) fl++;
            else if (fl > 0) begin report(K_FAIL, fl); fl = 0; end
            if (locked === 1'b1) ll++;
            else if (ll > 0) begin report(K_LOCK, ll); ll = 0; end
        end
    end

    task automatic step(input logic kv, input logic [3:0] k, input logic c);
        @(negedge clk);
        key_valid = kv;
        key       = k;
        cancel    = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0);
    endtask

    task automatic enter(input logic [15:0] seq);
        logic [15:0] s;
        s = seq;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, s[15:12], 1'b0);
            s = s << 4;
        end
        step(1'b0, 4'd0, 1'b0);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((pass || fail || locked) && n < 200) begin
            step(1'b0, 4'd0, 1'b0);
            n++;
        end
        if (n >= 200) chk({nm, "_timeout"}, 1, 0);
        idle(2);
    endtask

    initial begin
        clr_n     = 1'b0;
        code      = 16'h1234;
        key_valid = 1'b0;
        key       = 4'd0;
        cancel    = 1'b0;
        #1;
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_locked", locked, 0);
        chk("rst_digit_cnt", digit_cnt, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        idle(2);

        // Correct code
        expect_ev(K_PASS, 16);
        enter(16'h1234);
        chk("t1_pass_latency", pass, 1);
        chk("t1_fail", fail, 0);
        chk("t1_fail_cnt", fail_cnt, 0);
        wait_idle("t1");

        // Late reject
        expect_ev(K_FAIL, 1);
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd9, 1'b0);
        step(1'b1, 4'd3, 1'b0);
        chk("t2_no_early_fail", fail, 0);
        chk("t2_digit_cnt", digit_cnt, 2);
        step(1'b1, 4'd4, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        chk("t2_fail", fail, 1);
        chk("t2_fail_cnt", fail_cnt, 1);
        chk("t2_pass", pass, 0);
        wait_idle("t2");

        // Cancel wins over same-cycle key
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd3, 1'b1);
        step(1'b0, 4'd0, 1'b0);
        chk("t4_digit_cnt", digit_cnt, 0);
        chk("t4_fail_cnt", fail_cnt, 1);
        expect_ev(K_PASS, 16);
        enter(16'h1234);
        chk("t4_pass", pass, 1);
        chk("t4_fail_cnt_clr", fail_cnt, 0);
        wait_idle("t4");

        // Lockout after three consecutive failures
        for (int r = 0; r < 3; r++) begin
            expect_ev(K_FAIL, 1);
            enter(16'h5678);
            chk("t3_fail_cnt", fail_cnt, r + 1);
            if (r < 2) idle(2);
        end
        expect_ev(K_LOCK, 64);
        step(1'b0, 4'd0, 1'b0);
        chk("t3_locked", locked, 1);
        enter(16'h1234);
        chk("t3_lock_digit_cnt", digit_cnt, 0);
        chk("t3_lock_pass", pass, 0);
        chk("t3_lock_fail_cnt", fail_cnt, 3);
        wait_idle("t3");
        chk("t3_unlock_fail_cnt", fail_cnt, 0);
        expect_ev(K_PASS, 16);
        enter(16'h1234);
        chk("t3_pass", pass, 1);
        wait_idle("t3b");

        // Reset during OPEN cycle 5
        expect_ev(K_PASS, 5);
        enter(16'h1234);
        idle(4);
        #2;
        clr_n = 1'b0;
        #1;
        chk("t5_async_pass", pass, 0);
        chk("t5_digit_cnt", digit_cnt, 0);
        @(negedge clk);
        clr_n = 1'b1;
        idle(2);
        chk("t5_post_digit_cnt", digit_cnt, 0);
        chk("t5_post_fail_cnt", fail_cnt, 0);
        chk("t5_post_pass", pass, 0);

        // Partial entry left idle for 10 cycles
        step(1'b1, 4'd1, 1'b0);
        idle(11);
`ifdef ENTRY_TIMEOUT_EN
        chk("t6_timeout_digit_cnt", digit_cnt, 0);
`else
        chk("t6_hold_digit_cnt", digit_cnt, 1);
`endif
        chk("t6_fail", fail, 0);
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b0);
        expect_ev(K_PASS, 16);
        enter(16'h1234);
        chk("t6_pass", pass, 1);
        wait_idle("t6");

        chk("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
